// File: rtl/matrix_keypad_scanner_if.sv
// Keypad pin bundle plus debounced key report.
// master: scanner side (drives ROW/KEY_*), slave: board side (drives COL).
interface matrix_keypad_scanner_if;
  logic [3:0] COL;
  logic [3:0] ROW;
  logic [3:0] KEY_CODE;
  logic       KEY_VALID;
  logic       KEY_HELD;

  modport master (
    input  COL,
    output ROW, KEY_CODE, KEY_VALID, KEY_HELD
  );

  modport slave (
    output COL,
    input  ROW, KEY_CODE, KEY_VALID, KEY_HELD
  );
endinterface

// File: rtl/matrix_keypad_scanner.sv
// 4x4 keypad scanner: row drive, column sync, scan classify, debounce.
// Ports: CLOCK_50, RESET_N (async low), kp (master: COL in; ROW, KEY_* out).
module matrix_keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic CLOCK_50,
  input logic RESET_N,
  matrix_keypad_scanner_if.master kp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {
    IDLE, PRESS_CHK, HELD, REL_CHK
  } state_e;

  logic [3:0]    col_s1_q, col_s2_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    row_q, row_d;
  logic          acc_any_q, acc_any_d;
  logic          acc_multi_q, acc_multi_d;
  logic [3:0]    acc_code_q, acc_code_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;

  logic          div_wrap, scan_done;
  logic [3:0]    low;
  logic [2:0]    n_low;
  logic [1:0]    col_idx;
  logic          base_any, base_multi;
  logic          scan_any, scan_multi;
  logic [3:0]    scan_code;
  logic          single, none;

  always_comb begin
    div_wrap = div_q == DW'(SCAN_DIV - 1);
    div_d    = div_wrap ? '0 : div_q + DW'(1);
    row_d    = div_wrap ? row_q + 2'd1 : row_q;
    low      = ~col_s2_q;
    n_low    = {2'b0, low[0]} + {2'b0, low[1]}
             + {2'b0, low[2]} + {2'b0, low[3]};
    col_idx  = 2'd0;
    for (int i = 0; i < 4; i++)
      if (low[i]) col_idx = 2'(i);
    // row 0 sample starts a fresh scan
    base_any   = (row_q == 2'd0) ? 1'b0 : acc_any_q;
    base_multi = (row_q == 2'd0) ? 1'b0 : acc_multi_q;
    scan_any   = base_any | (n_low != 3'd0);
    scan_multi = base_multi | (n_low > 3'd1)
               | (base_any & (n_low != 3'd0));
    scan_code  = (n_low == 3'd1) ? {row_q, col_idx}
                                 : acc_code_q;
    acc_any_d   = div_wrap ? scan_any   : acc_any_q;
    acc_multi_d = div_wrap ? scan_multi : acc_multi_q;
    acc_code_d  = div_wrap ? scan_code  : acc_code_q;
    scan_done   = div_wrap && (row_q == 2'd3);
    single      = scan_any && !scan_multi;
    none        = !scan_any;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
    cnt_inc = (cnt_q == CW'(DEBOUNCE_SCANS)) ? cnt_q
                                            : cnt_q + CW'(1);
    if (scan_done) begin
      unique case (state_q)
        IDLE: begin
          if (single) begin
            cand_d  = scan_code;
            cnt_d   = CW'(1);
            state_d = PRESS_CHK;
          end
        end
        PRESS_CHK: begin
          if (single && scan_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              state_d = HELD;
              code_d  = cand_q;
              valid_d = 1'b1;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (none) begin
            cnt_d   = CW'(1);
            state_d = REL_CHK;
          end
        end
        REL_CHK: begin
          if (none) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      col_s1_q    <= 4'hF;
      col_s2_q    <= 4'hF;
      div_q       <= '0;
      row_q       <= 2'd0;
      acc_any_q   <= 1'b0;
      acc_multi_q <= 1'b0;
      acc_code_q  <= 4'd0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= 4'd0;
      code_q      <= 4'd0;
      valid_q     <= 1'b0;
    end else begin
      col_s1_q    <= kp.COL;
      col_s2_q    <= col_s1_q;
      div_q       <= div_d;
      row_q       <= row_d;
      acc_any_q   <= acc_any_d;
      acc_multi_q <= acc_multi_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
    end
  end

  assign kp.ROW       = ~(4'b0001 << row_q);
  assign kp.KEY_CODE  = code_q;
  assign kp.KEY_VALID = valid_q;
  assign kp.KEY_HELD  = (state_q == HELD) || (state_q == REL_CHK);

endmodule
